// File: rtl/slack_horizon_sched_pkg.sv
// Shared types and defaults for the slack-phase horizon sequencer.
package slack_horizon_sched_pkg;

  localparam int DEF_STATE_DIM   = 12;
  localparam int DEF_CONTROL_DIM = 4;
  localparam int DEF_W           = 16;
  localparam int DEF_HORIZON     = 10;
  localparam int DEF_TIMEOUT     = 255;

  // One signed fixed-point trajectory word.
  typedef logic signed [DEF_W-1:0] fixed_t;

  // Sequencer states; one knot walks READ -> LOAD -> KICK -> WAIT -> WRITE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WRITE = 3'd5,
    ST_FIN   = 3'd6
  } slack_sched_state_t;

  // Rising-edge detect against the previous-cycle sample.
  function automatic logic rising(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/slack_horizon_sched_if.sv
// Memory-read, slack_update and slack-memory-write bundle of the sequencer.
interface slack_horizon_sched_if
  import slack_horizon_sched_pkg::*;
#(
  parameter int STATE_DIM   = DEF_STATE_DIM,
  parameter int CONTROL_DIM = DEF_CONTROL_DIM,
  parameter int W           = DEF_W,
  parameter int AW          = $clog2(DEF_HORIZON)
);

  // trajectory memory read port
  logic                       rd_en;
  logic [AW-1:0]              rd_addr;
  logic [STATE_DIM*W-1:0]     rd_x;
  logic [STATE_DIM*W-1:0]     rd_y;
  logic [CONTROL_DIM*W-1:0]   rd_u;
  logic [CONTROL_DIM*W-1:0]   rd_g;

  // slack_update operands and results
  logic                       su_start;
  logic [STATE_DIM*W-1:0]     su_x;
  logic [STATE_DIM*W-1:0]     su_y;
  logic [CONTROL_DIM*W-1:0]   su_u;
  logic [CONTROL_DIM*W-1:0]   su_g;
  logic                       su_done;
  logic [STATE_DIM*W-1:0]     su_v;
  logic [CONTROL_DIM*W-1:0]   su_z;

  // slack memory write port
  logic                       wr_en;
  logic                       wr_z_en;
  logic [AW-1:0]              wr_addr;
  logic [STATE_DIM*W-1:0]     wr_v;
  logic [CONTROL_DIM*W-1:0]   wr_z;

  // sequencer side
  modport master (
    output rd_en, rd_addr,
    input  rd_x, rd_y, rd_u, rd_g,
    output su_start, su_x, su_y, su_u, su_g,
    input  su_done, su_v, su_z,
    output wr_en, wr_z_en, wr_addr, wr_v, wr_z
  );

  // memories / slack_update side
  modport slave (
    input  rd_en, rd_addr,
    output rd_x, rd_y, rd_u, rd_g,
    input  su_start, su_x, su_y, su_u, su_g,
    output su_done, su_v, su_z,
    input  wr_en, wr_z_en, wr_addr, wr_v, wr_z
  );

endinterface

// File: rtl/slack_horizon_sched_timeout_ctr.sv
// Watchdog counter for the WAIT state: cleared on kick, counts while enabled.
module sched_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;
  logic          at_limit;

  // The TIMEOUT-th enabled cycle is the one that reports expiry.
  assign at_limit = (cnt_reg >= CW'(TIMEOUT - 1));
  assign expired  = en & at_limit;

  // Count enabled cycles, saturating at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !at_limit) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/slack_horizon_sched.sv
// Sweeps one shared slack_update across every knot of the horizon.
module slack_horizon_sched
  import slack_horizon_sched_pkg::*;
#(
  parameter int STATE_DIM   = DEF_STATE_DIM,
  parameter int CONTROL_DIM = DEF_CONTROL_DIM,
  parameter int W           = DEF_W,
  parameter int HORIZON     = DEF_HORIZON,
  parameter int AW          = $clog2(HORIZON),
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [AW-1:0]         k_idx,
  slack_horizon_sched_if.master bus
);

  slack_sched_state_t state_reg, state_next;

  logic [AW-1:0] k_idx_reg;
  logic          err_reg;
  logic          su_done_q_reg;
  logic          done_edge;
  logic          last_knot;
  logic          tmo_clr;
  logic          tmo_en;
  logic          tmo_expired;
  logic          load_en;
  logic          cap_en;

  logic          busy_c, done_c, rd_en_c, su_start_c, wr_en_c, wr_z_en_c;

  // A held-high done from the previous knot never looks like a new edge.
  assign done_edge = rising(bus.su_done, su_done_q_reg);
  assign last_knot = (k_idx_reg == AW'(HORIZON - 1));
  assign load_en   = (state_reg == ST_LOAD);
  assign cap_en    = (state_reg == ST_WAIT) && done_edge;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode; a completion edge wins over a coincident timeout.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (start) state_next = ST_READ;
      ST_READ:  state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_KICK;
      ST_KICK:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (done_edge)        state_next = ST_WRITE;
        else if (tmo_expired) state_next = ST_FIN;
      end
      ST_WRITE: state_next = last_knot ? ST_FIN : ST_READ;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Moore strobes decoded from the state register.
  always_comb begin
    busy_c     = 1'b0;
    done_c     = 1'b0;
    rd_en_c    = 1'b0;
    su_start_c = 1'b0;
    wr_en_c    = 1'b0;
    wr_z_en_c  = 1'b0;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;
    unique case (state_reg)
      ST_IDLE:  ;
      ST_READ:  begin busy_c = 1'b1; rd_en_c = 1'b1; end
      ST_LOAD:  busy_c = 1'b1;
      ST_KICK:  begin busy_c = 1'b1; su_start_c = 1'b1; tmo_clr = 1'b1; end
      ST_WAIT:  begin busy_c = 1'b1; tmo_en = 1'b1; end
      ST_WRITE: begin
        busy_c    = 1'b1;
        wr_en_c   = 1'b1;
        // the terminal knot carries no control slack
        wr_z_en_c = ~last_knot;
      end
      ST_FIN:   begin busy_c = 1'b1; done_c = 1'b1; end
      default:  ;
    endcase
  end

  // Knot index, abort flag and the done-edge history sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_idx_reg     <= '0;
      err_reg       <= 1'b0;
      su_done_q_reg <= 1'b0;
    end else begin
      su_done_q_reg <= bus.su_done;
      if (state_reg == ST_IDLE && start) begin
        k_idx_reg <= '0;
        err_reg   <= 1'b0;
      end else if (state_reg == ST_WAIT && !done_edge && tmo_expired) begin
        err_reg <= 1'b1;
      end else if (state_reg == ST_WRITE && !last_knot) begin
        k_idx_reg <= k_idx_reg + AW'(1);
      end
    end
  end

  sched_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // State-vector lanes: operands latched in LOAD, v captured on the done edge.
  for (genvar gi = 0; gi < STATE_DIM; gi++) begin : g_state_lane
    logic signed [W-1:0] x_reg, y_reg, v_reg;

    // Per-lane operand and result registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        x_reg <= '0;
        y_reg <= '0;
        v_reg <= '0;
      end else begin
        if (load_en) begin
          x_reg <= bus.rd_x[gi*W +: W];
          y_reg <= bus.rd_y[gi*W +: W];
        end
        if (cap_en) v_reg <= bus.su_v[gi*W +: W];
      end
    end

    assign bus.su_x[gi*W +: W] = x_reg;
    assign bus.su_y[gi*W +: W] = y_reg;
    assign bus.wr_v[gi*W +: W] = v_reg;
  end

  // Control-vector lanes: same rule as the state lanes, z instead of v.
  for (genvar gi = 0; gi < CONTROL_DIM; gi++) begin : g_ctrl_lane
    logic signed [W-1:0] u_reg, g_reg, z_reg;

    // Per-lane operand and result registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        u_reg <= '0;
        g_reg <= '0;
        z_reg <= '0;
      end else begin
        if (load_en) begin
          u_reg <= bus.rd_u[gi*W +: W];
          g_reg <= bus.rd_g[gi*W +: W];
        end
        if (cap_en) z_reg <= bus.su_z[gi*W +: W];
      end
    end

    assign bus.su_u[gi*W +: W] = u_reg;
    assign bus.su_g[gi*W +: W] = g_reg;
    assign bus.wr_z[gi*W +: W] = z_reg;
  end

  assign busy         = busy_c;
  assign done         = done_c;
  assign err          = err_reg;
  assign k_idx        = k_idx_reg;
  assign bus.rd_en    = rd_en_c;
  assign bus.rd_addr  = k_idx_reg;
  assign bus.su_start = su_start_c;
  assign bus.wr_en    = wr_en_c;
  assign bus.wr_z_en  = wr_z_en_c;
  assign bus.wr_addr  = k_idx_reg;

endmodule

// File: tb/tb_slack_horizon_sched.sv
// Directed bench for slack_horizon_sched with a behavioural slack_update.
module tb_slack_horizon_sched;
  import slack_horizon_sched_pkg::*;

  localparam int SD  = DEF_STATE_DIM;
  localparam int CD  = DEF_CONTROL_DIM;
  localparam int W   = DEF_W;
  localparam int H   = DEF_HORIZON;
  localparam int AW  = $clog2(H);
  localparam int TMO = DEF_TIMEOUT;
  localparam int L   = 3;
  localparam int SWEEP_CYC = H * (L + 4) + 2;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, done, err;
  logic [AW-1:0] k_idx;

  slack_horizon_sched_if #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .AW(AW)) bus ();

  slack_horizon_sched #(
    .STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .HORIZON(H), .AW(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .err(err), .k_idx(k_idx), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int salt    = 0;
  int stall_k = -1;
  bit level_mode = 1'b0;

  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, last_rd_cyc = 0;
  logic done_err = 1'b0;
  int kick_cyc [H];

  typedef struct {
    int              addr;
    logic            zen;
    logic [SD*W-1:0] v;
    logic [CD*W-1:0] z;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SD*W-1:0] mem_x(input int k);
    logic [SD*W-1:0] r;
    for (int i = 0; i < SD; i++) r[i*W +: W] = fixed_t'(k + 1 + 16*i + salt);
    return r;
  endfunction
  function automatic logic [SD*W-1:0] mem_y(input int k);
    logic [SD*W-1:0] r;
    for (int i = 0; i < SD; i++) r[i*W +: W] = fixed_t'(16'h4000 + 32*k + i + 3*salt);
    return r;
  endfunction
  function automatic logic [CD*W-1:0] mem_u(input int k);
    logic [CD*W-1:0] r;
    for (int i = 0; i < CD; i++) r[i*W +: W] = fixed_t'(k + 2 + 16*i + salt);
    return r;
  endfunction
  function automatic logic [CD*W-1:0] mem_g(input int k);
    logic [CD*W-1:0] r;
    for (int i = 0; i < CD; i++) r[i*W +: W] = fixed_t'(16'h2000 + 32*k + i + 5*salt);
    return r;
  endfunction

  // Expected write stream for knots 0..n-1.
  task automatic push_sweep(input int n);
    for (int k = 0; k < n; k++)
      sb.push_back('{addr: k, zen: (k != H-1), v: mem_x(k) ^ mem_y(k), z: mem_u(k) ^ mem_g(k)});
  endtask

  // Trajectory memory: data valid exactly one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_x <= mem_x(int'(bus.rd_addr));
      bus.rd_y <= mem_y(int'(bus.rd_addr));
      bus.rd_u <= mem_u(int'(bus.rd_addr));
      bus.rd_g <= mem_g(int'(bus.rd_addr));
    end else begin
      bus.rd_x <= {SD{16'hDEAD}};
      bus.rd_y <= {SD{16'hBEEF}};
      bus.rd_u <= {CD{16'hDEAD}};
      bus.rd_g <= {CD{16'hBEEF}};
    end
  end

  // Behavioural slack_update: done edge L cycles after su_start, optional level hold.
  int m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt       <= 0;
      bus.su_done <= 1'b0;
      bus.su_v    <= '0;
      bus.su_z    <= '0;
    end else if (bus.su_start) begin
      m_cnt       <= (int'(k_idx) == stall_k) ? 0 : 1;
      bus.su_done <= 1'b0;
    end else if (m_cnt != 0) begin
      if (m_cnt == L - 1) begin
        m_cnt       <= 0;
        bus.su_done <= 1'b1;
        bus.su_v    <= bus.su_x ^ bus.su_y;
        bus.su_z    <= bus.su_u ^ bus.su_g;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (!level_mode) begin
      bus.su_done <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: operand timing, scoreboard pops on writes, done bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_en) last_rd_cyc = cyc;
      if (bus.su_start) begin
        check("kick_gap", 256'(cyc - last_rd_cyc), 256'(2));
        check("kick_su_x", 256'(bus.su_x), 256'(mem_x(int'(k_idx))));
        check("kick_su_u", 256'(bus.su_u), 256'(mem_u(int'(k_idx))));
        kick_cyc[k_idx] = cyc;
      end
      if (bus.wr_en) begin
        wr_cnt++;
        check("wr_expected", 256'(sb.size() > 0), 256'(1));
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          $display("[TB] write k=%0d z_en=%0b v=%0h z=%0h", bus.wr_addr, bus.wr_z_en, bus.wr_v, bus.wr_z);
          check("wr_addr", 256'(bus.wr_addr), 256'(mon_e.addr));
          check("wr_z_en", 256'(bus.wr_z_en), 256'(mon_e.zen));
          check("wr_v", 256'(bus.wr_v), 256'(mon_e.v));
          check("wr_z", 256'(bus.wr_z), 256'(mon_e.z));
          check("su_x_hold", 256'(bus.su_x), 256'(mem_x(int'(bus.wr_addr))));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_ctrl"}, 256'({busy, done, err, bus.rd_en, bus.su_start, bus.wr_en, bus.wr_z_en}), 256'(0));
    check({tag, "_addr"}, 256'({k_idx, bus.rd_addr, bus.wr_addr}), 256'(0));
    check({tag, "_ops"}, 256'({bus.su_x, bus.su_u}), 256'(0));
    check({tag, "_wdata"}, 256'({bus.wr_v, bus.wr_z}), 256'(0));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int  d0;
    bit  ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 256'(ok), 256'(1));
  endtask

  task automatic wait_knot(input string tag, input int k, input bit need_kick);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (int'(k_idx) == k && (!need_kick || bus.su_start)) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_knot_reached"}, 256'(ok), 256'(1));
  endtask

  task automatic nominal_sweep(input string tag, input int s);
    int w0;
    salt = s;
    push_sweep(H);
    w0 = wr_cnt;
    pulse_start();
    wait_done(tag, 400);
    check({tag, "_cycles"}, 256'(done_cyc - start_cyc + 1), 256'(SWEEP_CYC));
    check({tag, "_err"}, 256'(done_err), 256'(0));
    check({tag, "_writes"}, 256'(wr_cnt - w0), 256'(H));
    check({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, 256'({done, busy}), 256'(0));
    $display("[TB] sweep %s: %0d cycles, err=%0b", tag, done_cyc - start_cyc + 1, done_err);
  endtask

  initial begin
    int w0, d0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_idle_zero("post_rst");

    // nominal pulse-mode sweep
    nominal_sweep("nominal", 0);

    // level-held done from the model
    level_mode = 1'b1;
    nominal_sweep("level", 37);
    level_mode = 1'b0;

    // start re-pulsed mid-sweep at k=5
    salt = 5;
    push_sweep(H);
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    wait_knot("midstart", 5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart", 400);
    check("midstart_cycles", 256'(done_cyc - start_cyc + 1), 256'(SWEEP_CYC));
    repeat (20) @(negedge clk);
    #1;
    check("midstart_single_done", 256'(done_cnt - d0), 256'(1));
    check("midstart_writes", 256'(wr_cnt - w0), 256'(H));
    check("midstart_idle", 256'(busy), 256'(0));
    $display("[TB] midstart: %0d done pulses, %0d writes", done_cnt - d0, wr_cnt - w0);

    // timeout at knot 3
    salt = 9;
    stall_k = 3;
    push_sweep(3);
    w0 = wr_cnt;
    pulse_start();
    wait_done("timeout", 800);
    check("timeout_err", 256'(done_err), 256'(1));
    check("timeout_latency", 256'(done_cyc - kick_cyc[3]), 256'(TMO + 1));
    check("timeout_writes", 256'(wr_cnt - w0), 256'(3));
    check("timeout_sb_empty", 256'(sb.size()), 256'(0));
    stall_k = -1;
    @(negedge clk);
    #1;
    check("timeout_err_hold", 256'({busy, err}), 256'(1));
    $display("[TB] timeout: err=%0b latency=%0d", done_err, done_cyc - kick_cyc[3]);

    // next start clears err, full sweep follows
    salt = 11;
    push_sweep(H);
    w0 = wr_cnt;
    pulse_start();
    #1;
    check("err_cleared", 256'(err), 256'(0));
    wait_done("after_tmo", 400);
    check("after_tmo_err", 256'(done_err), 256'(0));
    check("after_tmo_writes", 256'(wr_cnt - w0), 256'(H));

    // async reset in WAIT at k=4
    salt = 13;
    push_sweep(H);
    pulse_start();
    wait_knot("arst", 4, 1'b1);
    @(negedge clk);
    #1;
    w0 = wr_cnt;
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check_idle_zero("arst");
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (15) @(negedge clk);
    #1;
    check("arst_no_write", 256'(wr_cnt - w0), 256'(0));
    check("arst_no_done", 256'(done_cnt - d0), 256'(0));
    check("arst_idle", 256'(busy), 256'(0));
    $display("[TB] async reset mid-WAIT: writes after=%0d done after=%0d", wr_cnt - w0, done_cnt - d0);
    nominal_sweep("after_arst", 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
